// File: rtl/config_access_scanner_if.sv
// Change-event channel: one source index plus its new C_bits per valid/ready beat.
// Sources hold Evt_src/Evt_bits stable while Evt_valid is high and Evt_ready is low.
interface config_access_scanner_if #(
  parameter int IDX_W        = 2,
  parameter int BITS_PER_SRC = 4
);
  logic                    Evt_valid;
  logic                    Evt_ready;
  logic [IDX_W-1:0]        Evt_src;
  logic [BITS_PER_SRC-1:0] Evt_bits;

  modport master (output Evt_valid, Evt_src, Evt_bits, input Evt_ready);
  modport slave  (input Evt_valid, Evt_src, Evt_bits, output Evt_ready);
endinterface

// File: rtl/config_access_scanner.sv
// Syncs Config_access C_bits and keeps a settled snapshot; Snapshot follows an input change in STABLE_CYCLES+3 edges.
// Changed sources become round-robin events; a stalled event is held, and pending changes merge per source.
module config_access_scanner #(
  parameter int NUM_SRC       = 4,
  parameter int BITS_PER_SRC  = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int IDX_W         = 2,
  parameter int CNT_W         = 3
) (
  input  logic                              CLK,
  input  logic                              resetn,
  input  logic                              ConfigBusy,
  input  logic [NUM_SRC*BITS_PER_SRC-1:0]   C_bits,
  output logic [NUM_SRC*BITS_PER_SRC-1:0]   Snapshot,
  output logic                              SnapshotValid,
  config_access_scanner_if.master           evt
);
  localparam int W = NUM_SRC * BITS_PER_SRC;

  typedef enum logic [1:0] {S_INIT, S_BUSY, S_SETTLE, S_RUN} state_t;

  logic [W-1:0]             bits_m, bits_s, bits_p;
  logic                     busy_m, busy_s;
  logic                     chg;
  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic                     capture;
  logic [NUM_SRC-1:0]       pending, pending_nxt, diff, grant_mask;
  logic [BITS_PER_SRC-1:0]  snap_slice [NUM_SRC];
  logic [IDX_W-1:0]         rr, grant_idx;
  logic                     grant_vld, evt_grant;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      bits_m <= '0;
      bits_s <= '0;
      bits_p <= '0;
      busy_m <= 1'b0;
      busy_s <= 1'b0;
    end else begin
      bits_m <= C_bits;
      bits_s <= bits_m;
      bits_p <= bits_s;
      busy_m <= ConfigBusy;
      busy_s <= busy_m;
    end
  end

  assign chg = (bits_s != bits_p);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slice
    assign snap_slice[i] = Snapshot[i*BITS_PER_SRC +: BITS_PER_SRC];
    assign diff[i]       = (bits_s[i*BITS_PER_SRC +: BITS_PER_SRC] != snap_slice[i]);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      S_INIT: begin
        state_nxt = busy_s ? S_BUSY : S_SETTLE;
        cnt_nxt   = '0;
      end
      S_BUSY: begin
        if (!busy_s) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = '0;
        end
      end
      S_SETTLE: begin
        if (busy_s) begin
          state_nxt = S_BUSY;
        end else if (chg) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          capture   = 1'b1;
          state_nxt = S_RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RUN: begin
        // A glitch outside reconfiguration is treated as a new settle window.
        if (busy_s) begin
          state_nxt = S_BUSY;
        end else if (chg) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // Scan downwards so the nearest pending index after rr is the one kept.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (pending[IDX_W'((int'(rr) + k) % NUM_SRC)]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'((int'(rr) + k) % NUM_SRC);
      end
    end
  end

  assign evt_grant   = grant_vld && !evt.Evt_valid;
  assign grant_mask  = evt_grant ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << grant_idx) : '0;
  // Capture sets after the grant clears, so a same-cycle change of the granted source survives.
  assign pending_nxt = (pending & ~grant_mask) | ((capture && SnapshotValid) ? diff : '0);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state         <= S_INIT;
      cnt           <= '0;
      Snapshot      <= '0;
      SnapshotValid <= 1'b0;
      pending       <= '0;
      rr            <= IDX_W'(NUM_SRC - 1);
      evt.Evt_valid <= 1'b0;
      evt.Evt_src   <= '0;
      evt.Evt_bits  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
      if (capture) begin
        Snapshot      <= bits_s;
        SnapshotValid <= 1'b1;
      end
      if (evt_grant) begin
        evt.Evt_valid <= 1'b1;
        evt.Evt_src   <= grant_idx;
        evt.Evt_bits  <= snap_slice[grant_idx];
        rr            <= grant_idx;
      end else if (evt.Evt_valid && evt.Evt_ready) begin
        evt.Evt_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_config_access_scanner.sv
// Scoreboard bench for config_access_scanner: expected events queued at stimulus, checked at handshake.
module tb_config_access_scanner;
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        busy = 1'b0;
  logic [15:0] c_bits = 16'h0;
  logic [15:0] snapshot;
  logic        snap_vld;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  typedef struct packed {
    logic [1:0] src;
    logic [3:0] bits;
  } evt_t;

  evt_t exp_q[$];
  int   hs_cyc[$];

  config_access_scanner_if #(.IDX_W(2), .BITS_PER_SRC(4)) evt_if();

  config_access_scanner #(
    .NUM_SRC(4), .BITS_PER_SRC(4), .STABLE_CYCLES(4), .IDX_W(2), .CNT_W(3)
  ) dut (
    .CLK(clk),
    .resetn(resetn),
    .ConfigBusy(busy),
    .C_bits(c_bits),
    .Snapshot(snapshot),
    .SnapshotValid(snap_vld),
    .evt(evt_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Handshake monitor: every accepted event must match the head of the scoreboard.
  always @(negedge clk) begin
    evt_t e;
    if (resetn && evt_if.Evt_valid && evt_if.Evt_ready) begin
      hs_cyc.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL evt_unexpected: got src=%0d bits=%h, expected no event", evt_if.Evt_src, evt_if.Evt_bits);
      end else begin
        e = exp_q.pop_front();
        if ({evt_if.Evt_src, evt_if.Evt_bits} !== e) begin
          bad++;
          $display("FAIL evt_data: got src=%0d bits=%h, expected src=%0d bits=%h",
                   evt_if.Evt_src, evt_if.Evt_bits, e.src, e.bits);
        end
      end
    end
  end

  task automatic apply_reset(input logic [15:0] bits);
    @(posedge clk); #1;
    resetn = 1'b0;
    c_bits = bits;
    busy   = 1'b0;
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    evt_if.Evt_ready = 1'b1;
    c_bits = 16'hA5C3;
    #1 resetn = 1'b0;
    #2;
    total++;
    if ({snapshot, snap_vld, evt_if.Evt_valid, evt_if.Evt_src, evt_if.Evt_bits} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got snap=%h vld=%b evt_vld=%b, expected all 0", snapshot, snap_vld, evt_if.Evt_valid);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    total++;
    if (snap_vld !== 1'b0) begin
      bad++;
      $display("FAIL t1_early_capture: SnapshotValid=%b after 6 edges, expected 0", snap_vld);
    end
    @(negedge clk);
    total++;
    if (snap_vld !== 1'b1 || snapshot !== 16'hA5C3) begin
      bad++;
      $display("FAIL t1_capture: vld=%b snap=%h after 7 edges, expected 1 a5c3", snap_vld, snapshot);
    end
    repeat (5) @(negedge clk);
    total++;
    if (evt_if.Evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL t1_no_event: Evt_valid=%b, expected 0", evt_if.Evt_valid);
    end
  endtask

  task automatic test_busy_hold;
    int n;
    @(posedge clk); #1;
    busy = 1'b1;
    exp_q.push_back('{src: 2'd0, bits: 4'h9});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1) c_bits = 16'hA5C9;
      total++;
      if (snapshot !== 16'hA5C3) begin
        bad++;
        $display("FAIL t2_hold_busy: snap=%h at busy cycle %0d, expected a5c3", snapshot, i);
      end
    end
    busy = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL t2_event_timeout: %0d events outstanding, expected 0", exp_q.size());
    end
    total++;
    if (snapshot !== 16'hA5C9) begin
      bad++;
      $display("FAIL t2_snapshot: snap=%h, expected a5c9", snapshot);
    end
  endtask

  task automatic test_all_change;
    int n;
    apply_reset(16'hA5C9);
    total++;
    if (snap_vld !== 1'b1 || snapshot !== 16'hA5C9) begin
      bad++;
      $display("FAIL t3_baseline: vld=%b snap=%h, expected 1 a5c9", snap_vld, snapshot);
    end
    evt_if.Evt_ready = 1'b1;
    hs_cyc.delete();
    exp_q.push_back('{src: 2'd0, bits: 4'hC});
    exp_q.push_back('{src: 2'd1, bits: 4'h3});
    exp_q.push_back('{src: 2'd2, bits: 4'hA});
    exp_q.push_back('{src: 2'd3, bits: 4'h5});
    c_bits = 16'h5A3C;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0 || hs_cyc.size() != 4) begin
      bad++;
      $display("FAIL t3_count: outstanding=%0d handshakes=%0d, expected 0 and 4", exp_q.size(), hs_cyc.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        total++;
        if (hs_cyc[i] - hs_cyc[i-1] != 2) begin
          bad++;
          $display("FAIL t3_spacing: gap %0d cycles before event %0d, expected 2", hs_cyc[i] - hs_cyc[i-1], i);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int n;
    apply_reset(16'hA5C9);
    evt_if.Evt_ready = 1'b0;
    exp_q.push_back('{src: 2'd0, bits: 4'hC});
    exp_q.push_back('{src: 2'd1, bits: 4'h3});
    exp_q.push_back('{src: 2'd2, bits: 4'hA});
    exp_q.push_back('{src: 2'd3, bits: 4'h5});
    c_bits = 16'h5A3C;
    n = 0;
    while (evt_if.Evt_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (evt_if.Evt_valid !== 1'b1 || evt_if.Evt_src !== 2'd0 || evt_if.Evt_bits !== 4'hC) begin
        bad++;
        $display("FAIL t4_hold: cycle %0d vld=%b src=%0d bits=%h, expected 1 0 c",
                 i, evt_if.Evt_valid, evt_if.Evt_src, evt_if.Evt_bits);
      end
    end
    @(posedge clk); #1;
    evt_if.Evt_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL t4_drain: %0d events outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_glitch;
    int n;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      c_bits[0] = ~c_bits[0];
      @(posedge clk);
      @(negedge clk);
      total++;
      if (snapshot !== 16'h5A3C) begin
        bad++;
        $display("FAIL t5_toggle_hold: snap=%h at toggle %0d, expected 5a3c", snapshot, i);
      end
    end
    exp_q.push_back('{src: 2'd0, bits: 4'hD});
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++;
    if (snapshot !== 16'h5A3C) begin
      bad++;
      $display("FAIL t5_early: snap=%h 6 edges after last toggle, expected 5a3c", snapshot);
    end
    @(negedge clk);
    total++;
    if (snapshot !== 16'h5A3D) begin
      bad++;
      $display("FAIL t5_capture: snap=%h 7 edges after last toggle, expected 5a3d", snapshot);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL t5_event: %0d events outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midevent;
    int n;
    @(posedge clk); #1;
    evt_if.Evt_ready = 1'b0;
    c_bits = 16'hFA3D;
    n = 0;
    while (evt_if.Evt_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (evt_if.Evt_valid !== 1'b1 || evt_if.Evt_src !== 2'd3 || evt_if.Evt_bits !== 4'hF) begin
      bad++;
      $display("FAIL t6_setup: vld=%b src=%0d bits=%h, expected 1 3 f", evt_if.Evt_valid, evt_if.Evt_src, evt_if.Evt_bits);
    end
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    total++;
    if ({snapshot, snap_vld, evt_if.Evt_valid, evt_if.Evt_src, evt_if.Evt_bits} !== '0) begin
      bad++;
      $display("FAIL t6_async_reset: snap=%h vld=%b evt_vld=%b, expected all 0", snapshot, snap_vld, evt_if.Evt_valid);
    end
    evt_if.Evt_ready = 1'b1;
    c_bits = 16'h1234;
    @(negedge clk);
    resetn = 1'b1;
    repeat (15) @(negedge clk);
    total++;
    if (snap_vld !== 1'b1 || snapshot !== 16'h1234 || evt_if.Evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL t6_first_capture: vld=%b snap=%h evt_vld=%b, expected 1 1234 0", snap_vld, snapshot, evt_if.Evt_valid);
    end
  endtask

  initial begin
    evt_if.Evt_ready = 1'b0;
    test_reset();
    test_busy_hold();
    test_all_change();
    test_backpressure();
    test_glitch();
    test_reset_midevent();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
